hiscore_upload_reader: RTL and testbench

- Reader end of the ioctl transfer path. The ROM/hiscore download path writes bytes from the host into the core; this block serves upload requests, returning bytes from core hiscore RAM to the host.
- Sits between data_io (upload side) and the game core's hs_* hiscore port, in the clk_sys (49.152 MHz) domain.
- Pauses the core for the whole session so reads do not collide with CPU writes.

---
 rtl/hiscore_pkg.sv | 17 +
 rtl/hiscore_upload_reader_edge.sv | 33 +++
 rtl/hiscore_upload_reader.sv | 204 ++++++++++++++++++++
 tb/tb_hiscore_upload_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_pkg.sv
// Shared definitions for the hiscore upload reader.
//   hs_state_t       : session FSM states (IDLE, PAUSE, READY, FETCH)
//   HS_INDEX_DEFAULT : ioctl_index value that identifies a hiscore upload
//   OOR_FILL         : byte returned for addresses outside the hiscore area
package hiscore_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_READY = 2'd2,
    ST_FETCH = 2'd3
  } hs_state_t;

  localparam logic [7:0] HS_INDEX_DEFAULT = 8'h03;
  localparam logic [7:0] OOR_FILL         = 8'hFF;

endpackage

// File: rtl/hiscore_upload_reader_edge.sv
// upload_edge_detect: registers ioctl_upload and produces single-cycle
// session start/stop pulses.
//   clk_sys, reset : system clock, async active-high reset
//   ioctl_upload   : upload session level from data_io
//   ioctl_index    : session index, qualifies the start pulse
//   start          : rising edge of ioctl_upload with a matching index
//   stop           : falling edge of ioctl_upload (any index)
// Both pulses are combinational from the live input and the registered copy,
// so the FSM reacts on the same clock edge that first samples the change.
module upload_edge_detect
  import hiscore_pkg::*;
#(
  parameter logic [7:0] HS_INDEX = HS_INDEX_DEFAULT
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ioctl_upload,
  input  logic [7:0] ioctl_index,
  output logic       start,
  output logic       stop
);

  logic upload_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) upload_q <= 1'b0;
    else       upload_q <= ioctl_upload;
  end

  assign start = ioctl_upload & ~upload_q & (ioctl_index == HS_INDEX);
  assign stop  = ~ioctl_upload & upload_q;

endmodule

// File: rtl/hiscore_upload_reader.sv
// hiscore_upload_reader: serves host upload reads from core hiscore RAM.
// Pauses the core for the whole session, then answers each ioctl_rd strobe
// with one byte on ioctl_din plus a one-cycle ioctl_din_valid pulse.
//   clk_sys, reset   : system clock, async active-high reset
//   ioctl_upload     : upload session active (level)
//   ioctl_index      : session index; only HS_INDEX opens a session
//   ioctl_addr       : byte address of the current request
//   ioctl_rd         : single-cycle read strobe
//   ioctl_din        : returned byte (held between requests)
//   ioctl_din_valid  : one-cycle pulse, ioctl_din valid from this cycle
//   pause_req        : holds the core CPUs paused
//   hs_address       : hiscore RAM address, stable while hs_access_read is high
//   hs_access_read   : core hs port granted for reading
//   hs_data_out      : core RAM read data
//   session_active   : high from session start until return to IDLE
//
// Handshake: ioctl_rd is a one-cycle strobe with no backpressure. A strobe
// that arrives while a fetch or the pause settle is in progress is held in a
// one-deep pending slot; a newer strobe overwrites it, so only the latest
// request is answered. Every accepted request yields exactly one
// ioctl_din_valid pulse unless the session ends first.
module hiscore_upload_reader
  import hiscore_pkg::*;
#(
  parameter int         ADDR_W       = 16,
  parameter logic [7:0] HS_INDEX     = HS_INDEX_DEFAULT,
  parameter int         HS_SIZE      = 256,
  parameter int         RD_LAT       = 2,
  parameter int         PAUSE_SETTLE = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_din_valid,
  output logic              pause_req,
  output logic [ADDR_W-1:0] hs_address,
  output logic              hs_access_read,
  input  logic [7:0]        hs_data_out,
  output logic              session_active
);

  localparam logic [3:0]  SETTLE_LOAD = 4'(PAUSE_SETTLE - 1);
  localparam logic [2:0]  LAT_LOAD    = 3'(RD_LAT);
  localparam logic [24:0] SIZE_25     = 25'(HS_SIZE);

  hs_state_t         state, state_n;
  logic [3:0]        settle_cnt, settle_cnt_n;
  logic [2:0]        lat_cnt, lat_cnt_n;
  logic              pend, pend_n;
  logic [24:0]       pend_addr, pend_addr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        din_q, din_n;
  logic              valid_q, valid_n;

  logic              start, stop;
  logic              req;
  logic [24:0]       req_addr;
  logic              req_in_range;

  upload_edge_detect #(
    .HS_INDEX (HS_INDEX)
  ) u_edge (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .start        (start),
    .stop         (stop)
  );

  // The request to serve next: a live strobe wins over the pending slot,
  // which is what makes "latest request wins" hold on every path.
  assign req          = ioctl_rd | pend;
  assign req_addr     = ioctl_rd ? ioctl_addr : pend_addr;
  assign req_in_range = (req_addr < SIZE_25);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      lat_cnt    <= '0;
      pend       <= 1'b0;
      pend_addr  <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      lat_cnt    <= lat_cnt_n;
      pend       <= pend_n;
      pend_addr  <= pend_addr_n;
      addr_q     <= addr_n;
      din_q      <= din_n;
      valid_q    <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    lat_cnt_n    = lat_cnt;
    pend_n       = pend;
    pend_addr_n  = pend_addr;
    addr_n       = addr_q;
    din_n        = din_q;
    valid_n      = 1'b0;

    case (state)
      ST_IDLE: begin
        pend_n = 1'b0;
        if (start) begin
          state_n      = ST_PAUSE;
          settle_cnt_n = SETTLE_LOAD;
        end
      end

      ST_PAUSE: begin
        if (ioctl_rd) begin
          pend_n      = 1'b1;
          pend_addr_n = ioctl_addr;
        end
        if (settle_cnt == 4'd0) begin
          state_n = ST_READY;
          if (req && req_in_range) begin
            state_n   = ST_FETCH;
            addr_n    = req_addr[ADDR_W-1:0];
            lat_cnt_n = LAT_LOAD;
            pend_n    = 1'b0;
          end else if (req) begin
            din_n   = OOR_FILL;
            valid_n = 1'b1;
            pend_n  = 1'b0;
          end
        end else begin
          settle_cnt_n = settle_cnt - 4'd1;
        end
      end

      ST_READY: begin
        if (req && req_in_range) begin
          state_n   = ST_FETCH;
          addr_n    = req_addr[ADDR_W-1:0];
          lat_cnt_n = LAT_LOAD;
          pend_n    = 1'b0;
        end else if (req) begin
          // Out of range: answer directly, the RAM is never touched.
          din_n   = OOR_FILL;
          valid_n = 1'b1;
          pend_n  = 1'b0;
        end
      end

      ST_FETCH: begin
        // Capture on the edge where the latency counter reaches zero.
        if (lat_cnt == 3'd1) begin
          din_n   = hs_data_out;
          valid_n = 1'b1;
          if (req && req_in_range) begin
            addr_n    = req_addr[ADDR_W-1:0];
            lat_cnt_n = LAT_LOAD;
            pend_n    = 1'b0;
          end else begin
            // An out-of-range request waiting here is answered from READY
            // on the next cycle so it gets its own valid pulse.
            state_n     = ST_READY;
            pend_n      = req;
            pend_addr_n = req_addr;
          end
        end else begin
          lat_cnt_n = lat_cnt - 3'd1;
          if (ioctl_rd) begin
            pend_n      = 1'b1;
            pend_addr_n = ioctl_addr;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Session end overrides everything: in-flight work is dropped silently
    // and a strobe on the same cycle is ignored.
    if (stop && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
      pend_n  = 1'b0;
      valid_n = 1'b0;
      din_n   = din_q;
      addr_n  = addr_q;
    end
  end

  assign pause_req       = (state != ST_IDLE);
  assign session_active  = (state != ST_IDLE);
  assign hs_access_read  = (state == ST_FETCH);
  assign hs_address      = addr_q;
  assign ioctl_din       = din_q;
  assign ioctl_din_valid = valid_q;

endmodule

// File: tb/tb_hiscore_upload_reader.sv
// Bench for hiscore_upload_reader: random reads against a transaction-level
// model (byte = RAM content or 8'hFF, fixed latency per address class).
module tb_hiscore_upload_reader;

  localparam int         ADDR_W       = 16;
  localparam int         HS_SIZE      = 256;
  localparam int         RD_LAT       = 2;
  localparam int         PAUSE_SETTLE = 4;
  localparam logic [7:0] HS_INDEX     = 8'h03;

  // ---------------- clock / reset ----------------
  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic              ioctl_rd;
  logic [7:0]        ioctl_din;
  logic              ioctl_din_valid;
  logic              pause_req;
  logic [ADDR_W-1:0] hs_address;
  logic              hs_access_read;
  logic [7:0]        hs_data_out;
  logic              session_active;

  always #5 clk_sys = ~clk_sys;

  hiscore_upload_reader #(
    .ADDR_W       (ADDR_W),
    .HS_INDEX     (HS_INDEX),
    .HS_SIZE      (HS_SIZE),
    .RD_LAT       (RD_LAT),
    .PAUSE_SETTLE (PAUSE_SETTLE)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ioctl_upload    (ioctl_upload),
    .ioctl_index     (ioctl_index),
    .ioctl_addr      (ioctl_addr),
    .ioctl_rd        (ioctl_rd),
    .ioctl_din       (ioctl_din),
    .ioctl_din_valid (ioctl_din_valid),
    .pause_req       (pause_req),
    .hs_address      (hs_address),
    .hs_access_read  (hs_access_read),
    .hs_data_out     (hs_data_out),
    .session_active  (session_active)
  );

  // Core hiscore RAM: the hs_address register plus one RAM stage make up
  // the RD_LAT=2 read path.
  logic [7:0] mem [HS_SIZE];
  always @(posedge clk_sys) hs_data_out <= mem[hs_address[7:0]];

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         acc_cnt = 0;
  int         last_acc_rise = -1;
  logic       acc_prev = 1'b0;
  int         total = 0;
  int         bad = 0;

  always @(negedge clk_sys) begin
    if (ioctl_din_valid) begin
      got_q.push_back(ioctl_din);
      got_t.push_back(cyc);
    end
    if (hs_access_read) acc_cnt = acc_cnt + 1;
    if (hs_access_read && !acc_prev) last_acc_rise = cyc;
    acc_prev = hs_access_read;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the host should get back and when.
  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    if (a < 25'(HS_SIZE)) return mem[a[7:0]];
    return 8'hFF;
  endfunction

  function automatic int ref_lat(input logic [24:0] a);
    return (a < 25'(HS_SIZE)) ? RD_LAT + 1 : 1;
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      check({tag, "_time"}, 32'(got_t.pop_front()), 32'(exp_t.pop_front()));
    end
    exp_q.delete();
    exp_t.delete();
    got_q.delete();
    got_t.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input bit expect_reply);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    if (expect_reply) begin
      exp_q.push_back(ref_byte(a));
      exp_t.push_back(cyc + ref_lat(a));
    end
    tick();
    ioctl_rd = 1'b0;
  endtask

  task automatic single_read(input logic [24:0] a);
    int         acc0;
    logic [7:0] d;
    acc0 = acc_cnt;
    d    = ref_byte(a);
    strobe(a, 1'b1);
    if (a < 25'(HS_SIZE)) begin
      check("rd_addr", 32'(hs_address), 32'(a));
      check("rd_acc", 32'(hs_access_read), 32'd1);
    end
    repeat (RD_LAT + 2) tick();
    if (a >= 25'(HS_SIZE)) check("oor_noacc", 32'(acc_cnt - acc0), 32'd0);
    check("din_hold", 32'(ioctl_din), 32'(d));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          k, off, acc0;
    logic [24:0] a, a1, a2;

    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'h00;
    ioctl_addr   = '0;
    ioctl_rd     = 1'b0;
    for (int i = 0; i < HS_SIZE; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[8'h10] = 8'h5A;

    repeat (3) tick();
    check("rst_pause", 32'(pause_req), 32'd0);
    check("rst_valid", 32'(ioctl_din_valid), 32'd0);
    check("rst_din", 32'(ioctl_din), 32'd0);
    check("rst_addr", 32'(hs_address), 32'd0);
    check("rst_acc", 32'(hs_access_read), 32'd0);
    check("rst_sess", 32'(session_active), 32'd0);
    reset = 1'b0;
    tick();

    // Session start and plain reads from READY.
    ioctl_index  = HS_INDEX;
    ioctl_upload = 1'b1;
    tick();
    check("start_pause", 32'(pause_req), 32'd1);
    check("start_sess", 32'(session_active), 32'd1);
    check("start_noacc", 32'(hs_access_read), 32'd0);
    repeat (PAUSE_SETTLE) tick();

    single_read(25'h10);
    single_read(25'h0FF);
    single_read(25'h100);
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) == 0) a = 25'($urandom_range(256, 33554431));
      else                           a = 25'($urandom_range(0, 255));
      single_read(a);
    end
    compare_outputs("reads");

    ioctl_upload = 1'b0;
    tick();
    check("end_pause", 32'(pause_req), 32'd0);
    check("end_sess", 32'(session_active), 32'd0);
    tick();

    // Request during PAUSE, second one during FETCH: back-to-back service.
    k            = cyc;
    ioctl_upload = 1'b1;
    tick();
    a1 = 25'($urandom_range(0, 255));
    a2 = 25'($urandom_range(0, 255));
    strobe(a1, 1'b0);
    exp_q.push_back(ref_byte(a1));
    exp_t.push_back(k + 1 + PAUSE_SETTLE + RD_LAT);
    off = $urandom_range(0, RD_LAT - 1);
    repeat (PAUSE_SETTLE - 1 + off) tick();
    strobe(a2, 1'b0);
    exp_q.push_back(ref_byte(a2));
    exp_t.push_back(k + 1 + PAUSE_SETTLE + 2 * RD_LAT);
    repeat (8) tick();
    compare_outputs("pend");
    check("settle_gap", 32'(last_acc_rise - (k + 1)), 32'(PAUSE_SETTLE));

    ioctl_upload = 1'b0;
    repeat (2) tick();

    // Two strobes in PAUSE: only the latest is answered.
    k            = cyc;
    ioctl_upload = 1'b1;
    tick();
    a1 = 25'($urandom_range(0, 255));
    a2 = 25'($urandom_range(0, 255));
    strobe(a1, 1'b0);
    strobe(a2, 1'b0);
    exp_q.push_back(ref_byte(a2));
    exp_t.push_back(k + 1 + PAUSE_SETTLE + RD_LAT);
    repeat (10) tick();
    compare_outputs("overwrite");

    // Session ends mid-FETCH: no reply, everything drops next cycle.
    a = 25'($urandom_range(0, 255));
    strobe(a, 1'b0);
    off = $urandom_range(0, RD_LAT - 1);
    repeat (off) tick();
    ioctl_upload = 1'b0;
    tick();
    check("drop_pause", 32'(pause_req), 32'd0);
    check("drop_acc", 32'(hs_access_read), 32'd0);
    check("drop_sess", 32'(session_active), 32'd0);
    repeat (6) tick();
    compare_outputs("drop");

    // Upload pulse inside PAUSE with a strobe on the falling edge.
    acc0         = acc_cnt;
    ioctl_upload = 1'b1;
    tick();
    check("glitch_pause_on", 32'(pause_req), 32'd1);
    ioctl_addr   = 25'h05;
    ioctl_rd     = 1'b1;
    ioctl_upload = 1'b0;
    tick();
    ioctl_rd = 1'b0;
    check("glitch_pause_off", 32'(pause_req), 32'd0);
    repeat (10) tick();
    check("glitch_noacc", 32'(acc_cnt - acc0), 32'd0);
    compare_outputs("glitch");

    // Foreign index: no session, strobes ignored.
    acc0         = acc_cnt;
    ioctl_index  = 8'h00;
    ioctl_upload = 1'b1;
    tick();
    check("idx0_pause", 32'(pause_req), 32'd0);
    repeat (PAUSE_SETTLE + 1) tick();
    strobe(25'h10, 1'b0);
    strobe(25'h100, 1'b0);
    repeat (6) tick();
    check("idx0_sess", 32'(session_active), 32'd0);
    check("idx0_noacc", 32'(acc_cnt - acc0), 32'd0);
    compare_outputs("idx0");
    ioctl_upload = 1'b0;
    tick();

    // Asynchronous reset in the middle of a fetch.
    ioctl_index  = HS_INDEX;
    ioctl_upload = 1'b1;
    tick();
    repeat (PAUSE_SETTLE) tick();
    strobe(25'h10, 1'b0);
    check("prerst_acc", 32'(hs_access_read), 32'd1);
    check("prerst_addr", 32'(hs_address), 32'h10);
    #2 reset = 1'b1;
    #1;
    check("arst_pause", 32'(pause_req), 32'd0);
    check("arst_acc", 32'(hs_access_read), 32'd0);
    check("arst_sess", 32'(session_active), 32'd0);
    check("arst_addr", 32'(hs_address), 32'd0);
    check("arst_din", 32'(ioctl_din), 32'd0);
    check("arst_valid", 32'(ioctl_din_valid), 32'd0);
    ioctl_upload = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    compare_outputs("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
